// File: rtl/spi_ss_pkg.sv
// Shared types and helpers for the SPI master frame timer / slave-select controller.
// Holds the FSM state encoding, spi_mode decode constants and a constant clog2 helper.
// No logic lives here; the package is imported by the timer and the top.
package spi_ss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } ss_state_t;

    localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
    localparam logic [1:0] SPI_MODE_WAIT = 2'b01;
    localparam logic [1:0] SPI_MODE_STOP = 2'b10;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int spi_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_frame_timer.sv
// Loadable down-counter with terminal-count flag, shared by the SETUP, XFER and HOLD phases.
// Latency: load takes effect on the next edge; o_tc is a pure decode of the count (same cycle).
// Backpressure: none; counts down every cycle until it reaches zero and then holds.
module spi_frame_timer #(
    parameter int CNT_W = 19
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/spi_slave_select_ctrl_multi.sv
// SPI master frame timer and chip-select controller for NUM_SS slaves (optional macro: SPI_SS_CONT_EN).
// Latency: ss_n/tip change on the accept edge (1 cycle after send_data is sampled); receive_data 1 cycle after last XFER cycle.
// Backpressure: send_data is only honoured in IDLE (or on the last XFER cycle with SPI_SS_CONT_EN); other requests are dropped.
module spi_slave_select_ctrl_multi
    import spi_ss_pkg::*;
#(
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 12,
    parameter int FL_W   = 5,
    parameter int DLY_W  = 4,
    // One extra select bit so an out-of-range index is always expressible and can be flagged.
    localparam int SEL_W = spi_clog2(NUM_SS) + 1
) (
    input  logic             i_pclk,
    input  logic             i_presetn,
    input  logic             i_mstr,
    input  logic             i_spiswai,
    input  logic [1:0]       i_spi_mode,
    input  logic             i_send_data,
    input  logic [DIV_W-1:0] i_baud_rate_divisor,
    input  logic [FL_W-1:0]  i_frame_len,
    input  logic [SEL_W-1:0] i_ss_sel,
    input  logic [DLY_W-1:0] i_lead_dly,
    input  logic [DLY_W-1:0] i_trail_dly,
    output logic [NUM_SS-1:0] o_ss_n,
    output logic             o_tip,
    output logic             o_receive_data,
    output logic             o_sel_err
);

    // Wide enough for 2 * max_div * 2**FL_W without overflow.
    localparam int CNT_W = DIV_W + FL_W + 2;

    ss_state_t        r_state;
    ss_state_t        w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [FL_W-1:0]  r_flen;
    logic [DLY_W-1:0] r_trail;
    logic [SEL_W-1:0] r_sel;
    logic             r_sel_ok;
    logic             r_receive_data;
    logic             r_sel_err;

    logic             w_en;
    logic             w_tc;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_latch;
    logic             w_latch_sel;
    logic             w_rd_nxt;
    logic             w_err_nxt;
    logic             w_sel_in_ok;
    logic             w_cont_req;
    logic [CNT_W-1:0] w_xfer_in_m1;
    logic [CNT_W-1:0] w_xfer_lat_m1;

    // XFER length minus one: 2 * max(div,1) * (frame_len+1) - 1.
    function automatic logic [CNT_W-1:0] xfer_m1(input logic [DIV_W-1:0] div,
                                                 input logic [FL_W-1:0]  flen);
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] bits;
        d    = (div == '0) ? CNT_W'(1) : CNT_W'(div);
        bits = CNT_W'(flen) + CNT_W'(1);
        return ((d * bits) << 1) - CNT_W'(1);
    endfunction

    assign w_en          = i_mstr & ~i_spiswai &
                           ((i_spi_mode == SPI_MODE_RUN) || (i_spi_mode == SPI_MODE_WAIT));
    assign w_sel_in_ok   = (i_ss_sel < SEL_W'(NUM_SS));
    assign w_xfer_in_m1  = xfer_m1(i_baud_rate_divisor, i_frame_len);
    assign w_xfer_lat_m1 = xfer_m1(r_div, r_flen);

`ifdef SPI_SS_CONT_EN
    // A request on the last XFER cycle chains straight into the next frame.
    assign w_cont_req = i_send_data;
`else
    // Every frame returns through IDLE, so ss_n always deasserts between frames.
    assign w_cont_req = 1'b0;
`endif

    spi_frame_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_pclk),
        .i_rst_n    (i_presetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // State register.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, timer reload and latch/strobe decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_latch     = 1'b0;
        w_latch_sel = 1'b0;
        w_rd_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        if (!w_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_send_data) begin
                        w_latch     = 1'b1;
                        w_latch_sel = 1'b1;
                        w_err_nxt   = ~w_sel_in_ok;
                        w_load      = 1'b1;
                        if (i_lead_dly != '0) begin
                            w_state_nxt = ST_SETUP;
                            w_load_val  = CNT_W'(i_lead_dly) - CNT_W'(1);
                        end else begin
                            w_state_nxt = ST_XFER;
                            w_load_val  = w_xfer_in_m1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_tc) begin
                        w_state_nxt = ST_XFER;
                        w_load      = 1'b1;
                        w_load_val  = w_xfer_lat_m1;
                    end
                end
                ST_XFER: begin
                    if (w_tc) begin
                        w_rd_nxt = 1'b1;
                        if (w_cont_req) begin
                            // Fresh timing parameters, same slave stays selected.
                            w_latch     = 1'b1;
                            w_load      = 1'b1;
                            w_load_val  = w_xfer_in_m1;
                        end else if (r_trail != '0) begin
                            w_state_nxt = ST_HOLD;
                            w_load      = 1'b1;
                            w_load_val  = CNT_W'(r_trail) - CNT_W'(1);
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tc) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Frame parameters are captured at accept so mid-frame register writes have no effect.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_div    <= '0;
            r_flen   <= '0;
            r_trail  <= '0;
            r_sel    <= '0;
            r_sel_ok <= 1'b0;
        end else begin
            if (w_latch) begin
                r_div   <= i_baud_rate_divisor;
                r_flen  <= i_frame_len;
                r_trail <= i_trail_dly;
            end
            if (w_latch_sel) begin
                r_sel    <= i_ss_sel;
                r_sel_ok <= w_sel_in_ok;
            end
        end
    end

    // Single-cycle status strobes.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_receive_data <= 1'b0;
            r_sel_err      <= 1'b0;
        end else begin
            r_receive_data <= w_rd_nxt;
            r_sel_err      <= w_err_nxt;
        end
    end

    // One-hot-low select decode; all high in IDLE or when the latched index is out of range.
    always_comb begin
        o_ss_n = '1;
        if ((r_state != ST_IDLE) && r_sel_ok) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (r_sel == SEL_W'(i)) begin
                    o_ss_n[i] = 1'b0;
                end
            end
        end
    end

    assign o_tip          = (r_state != ST_IDLE);
    assign o_receive_data = r_receive_data;
    assign o_sel_err      = r_sel_err;

endmodule

// File: tb/tb_spi_slave_select_ctrl_multi.sv
// Self-checking bench for spi_slave_select_ctrl_multi (NUM_SS=4, so ss_sel is 3 bits wide).
// Expected waveforms come from a frame-timeline model: lead + T + trail low cycles, then IDLE.
// Build with SPI_SS_CONT_EN defined to exercise chained frames.
module tb_spi_slave_select_ctrl_multi;

    logic        clk;
    logic        rst_n;
    logic        mstr;
    logic        spiswai;
    logic [1:0]  spi_mode;
    logic        send;
    logic [11:0] div;
    logic [4:0]  flen;
    logic [2:0]  sel;
    logic [3:0]  lead;
    logic [3:0]  trail;
    logic [3:0]  ss_n;
    logic        tip;
    logic        rd;
    logic        serr;

    int checks;
    int errors;

    spi_slave_select_ctrl_multi dut (
        .i_pclk              (clk),
        .i_presetn           (rst_n),
        .i_mstr              (mstr),
        .i_spiswai           (spiswai),
        .i_spi_mode          (spi_mode),
        .i_send_data         (send),
        .i_baud_rate_divisor (div),
        .i_frame_len         (flen),
        .i_ss_sel            (sel),
        .i_lead_dly          (lead),
        .i_trail_dly         (trail),
        .o_ss_n              (ss_n),
        .o_tip               (tip),
        .o_receive_data      (rd),
        .o_sel_err           (serr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all four outputs against an expected bundle; one check.
    task automatic cmp(input string name, input int cyc, input logic [3:0] e_ss,
                       input logic e_tip, input logic e_rd, input logic e_err);
        checks++;
        if ({ss_n, tip, rd, serr} !== {e_ss, e_tip, e_rd, e_err}) begin
            errors++;
            $display("FAIL %s cyc=%0d got ss_n=%h tip=%b rd=%b err=%b want ss_n=%h tip=%b rd=%b err=%b",
                     name, cyc, ss_n, tip, rd, serr, e_ss, e_tip, e_rd, e_err);
        end
    endtask

    // Run nfr frames (send held for nfr>1) and check every cycle against the timeline model.
    task automatic check_frames(input string name, input int d, input int fl, input int ld,
                                input int tr, input int sl, input int nfr);
        int t, len, p, ncyc;
        logic [3:0] low;
        logic       e_tip;
        t    = 2 * ((d == 0) ? 1 : d) * (fl + 1);
        len  = ld + t + tr;
        low  = (sl < 4) ? ~(4'b0001 << sl) : 4'hF;
        ncyc = nfr * (len + 1);
        @(negedge clk);
        div = 12'(d); flen = 5'(fl); lead = 4'(ld); trail = 4'(tr); sel = 3'(sl);
        send = 1'b1;
        @(posedge clk);
        #1;
        if (nfr == 1) begin
            send  = 1'b0;
            div   = 12'($urandom);
            flen  = 5'($urandom);
            lead  = 4'($urandom);
            trail = 4'($urandom);
            sel   = 3'($urandom);
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            p     = (c - 1) % (len + 1) + 1;
            e_tip = (p <= len);
            cmp(name, c, e_tip ? low : 4'hF, e_tip, (p == ld + t + 1), (p == 1) && (sl >= 4));
            if (c == ncyc) send = 1'b0;
        end
        @(negedge clk);
        cmp({name, "_idle"}, ncyc + 1, 4'hF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mstr = 1'b1; spiswai = 1'b0; spi_mode = 2'b00; send = 1'b1;
        div = 12'd1; flen = 5'd7; sel = 3'd0; lead = 4'd0; trail = 4'd0;
        repeat (3) @(negedge clk);
        cmp("reset", 0, 4'hF, 1'b0, 1'b0, 1'b0);
        send = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        cmp("after_reset", 1, 4'hF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        check_frames("basic_8bit", 1, 7, 0, 0, 0, 1);
        check_frames("lead_trail", 3, 15, 2, 3, 2, 1);
        spi_mode = 2'b01;
        check_frames("wait_mode", 2, 3, 1, 0, 3, 1);
        spi_mode = 2'b00;
    endtask

    task automatic test_sel_err();
        check_frames("sel_err5", 2, 4, 1, 1, 5, 1);
        check_frames("sel_err4", 1, 0, 0, 2, 4, 1);
    endtask

    task automatic test_gate_mid_xfer();
        @(negedge clk);
        div = 12'd3; flen = 5'd15; lead = 4'd1; trail = 4'd2; sel = 3'd1; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (9) @(negedge clk);
        cmp("gate_pre", 10, 4'b1101, 1'b1, 1'b0, 1'b0);
        spiswai = 1'b1;
        @(negedge clk);
        cmp("gate_drop", 11, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 110; c++) begin
            if (c == 5) spiswai = 1'b0;
            @(negedge clk);
            cmp("gate_quiet", 12 + c, 4'hF, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_disabled();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mstr     = (k != 0);
            spi_mode = (k == 1) ? 2'b10 : ((k == 2) ? 2'b11 : 2'b00);
            spiswai  = (k == 3);
            div = 12'd1; flen = 5'd1; lead = 4'd0; sel = 3'd0; send = 1'b1;
            @(negedge clk);
            send = 1'b0;
            cmp("disabled", k, 4'hF, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        mstr = 1'b1; spi_mode = 2'b00; spiswai = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        div = 12'd2; flen = 5'd7; lead = 4'd0; trail = 4'd1; sel = 3'd2; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (4) @(negedge clk);
        cmp("pre_reset_mid", 5, 4'b1011, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        cmp("reset_mid", 6, 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("reset_mid_after", 7, 4'hF, 1'b0, 1'b0, 1'b0);
    endtask

`ifndef SPI_SS_CONT_EN
    task automatic test_back_to_back();
        check_frames("b2b_min", 0, 0, 0, 0, 0, 3);
        check_frames("b2b_dly", 1, 1, 1, 2, 3, 2);
    endtask
`else
    task automatic test_cont();
        logic [3:0] e_ss;
        @(negedge clk);
        div = 12'd1; flen = 5'd3; lead = 4'd1; trail = 4'd2; sel = 3'd3; send = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            e_ss = (c <= 19) ? 4'b0111 : 4'hF;
            cmp("cont", c, e_ss, (c <= 19), (c == 10) || (c == 18), 1'b0);
            if (c == 10) send = 1'b0;
        end
    endtask
`endif

    task automatic test_random();
        int d, fl, ld, tr, sl, nfr;
        for (int k = 0; k < 12; k++) begin
            d  = $urandom_range(0, 5);
            fl = $urandom_range(0, 15);
            ld = $urandom_range(0, 3);
            tr = $urandom_range(0, 3);
            sl = $urandom_range(0, 7);
`ifndef SPI_SS_CONT_EN
            nfr = $urandom_range(1, 2);
`else
            nfr = 1;
`endif
            check_frames("random", d, fl, ld, tr, sl, nfr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_sel_err();
        test_gate_mid_xfer();
        test_disabled();
        test_reset_mid();
`ifndef SPI_SS_CONT_EN
        test_back_to_back();
`else
        test_cont();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
